fifo_ptr_ctrl: RTL and testbench

//  Parametrised pointer/occupancy controller for a single-clock synchronous FIFO.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_wrap_ctr.sv | 27 ++
 rtl/fifo_ptr_ctrl.sv | 105 ++++++++++
 tb/tb_fifo_ptr_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO pointer/occupancy controller.
// Provides the default geometry and the address-width calculation.
package fifo_pkg;

  localparam int FIFO_DEPTH_DEF = 64;
  localparam int AF_MARGIN_DEF  = 4;
  localparam int AE_MARGIN_DEF  = 4;

  // Smallest r with (1 << r) >= depth; exact log2 for power-of-2 depths.
  function automatic int fifo_log2(input int depth);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wrap_ctr.sv
// Enabled AW-bit address counter with synchronous reset.
// Wraps DEPTH-1 -> 0 naturally because DEPTH is a power of 2.
module fifo_wrap_ctr #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [AW-1:0] value
);

  logic [AW-1:0] cnt_q;
  logic [AW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = cnt_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign value = cnt_q;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and status controller for a single-clock FIFO whose
// storage is an external dual-port RAM addressed by wr_addr/rd_addr.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH    = FIFO_DEPTH_DEF,
  parameter int AF_LEVEL = DEPTH - AF_MARGIN_DEF,
  parameter int AE_LEVEL = AE_MARGIN_DEF,
  localparam int AW      = fifo_log2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic          rd,
  input  logic          clr_err,
  output logic          wr_en,
  output logic          rd_en,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow
);

  generate
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("fifo_ptr_ctrl: DEPTH must be a power of 2 and >= 4");
    end
    if (AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
      $error("fifo_ptr_ctrl: AE_LEVEL must be below AF_LEVEL");
    end
  endgenerate

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

  logic [AW:0] count_q;
  logic [AW:0] count_d;
  logic        overflow_q;
  logic        overflow_d;
  logic        underflow_q;
  logic        underflow_d;

  // Request/accept: wr and rd are requests that may be held any number of
  // cycles; a transfer happens only in a cycle where wr_en/rd_en is high,
  // decided from the registered flags of that same cycle (no bypass).
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

  assign wr_en = wr & ~full;
  assign rd_en = rd & ~empty;

  fifo_wrap_ctr #(.AW(AW)) u_wr_ctr (
    .clk   (clk),
    .rst   (rst),
    .en    (wr_en),
    .value (wr_addr)
  );

  fifo_wrap_ctr #(.AW(AW)) u_rd_ctr (
    .clk   (clk),
    .rst   (rst),
    .en    (rd_en),
    .value (rd_addr)
  );

  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // A fresh error in the same cycle as clr_err keeps the flag set.
  always_comb begin
    overflow_d  = (wr & full)  | (overflow_q  & ~clr_err);
    underflow_d = (rd & empty) | (underflow_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed and random traffic for fifo_ptr_ctrl at DEPTH=8, AF=6, AE=2,
// with a bench-side RAM and an in-order data scoreboard.
module tb_fifo_ptr_ctrl;

  logic       clk;
  logic       rst;
  logic       wr;
  logic       rd;
  logic       clr_err;
  logic       wr_en;
  logic       rd_en;
  logic [2:0] wr_addr;
  logic [2:0] rd_addr;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  int checks;
  int failures;

  int         m_count;
  logic [2:0] m_wa;
  logic [2:0] m_ra;
  logic       m_ovf;
  logic       m_unf;

  logic [7:0] ram [8];
  logic [7:0] exp_q[$];
  logic [7:0] data_ctr;

  fifo_ptr_ctrl #(.DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr           (wr),
    .rd           (rd),
    .clr_err      (clr_err),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .wr_addr      (wr_addr),
    .rd_addr      (rd_addr),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"},        32'(count),        32'(m_count));
    check({tag, ".wr_addr"},      32'(wr_addr),      32'(m_wa));
    check({tag, ".rd_addr"},      32'(rd_addr),      32'(m_ra));
    check({tag, ".full"},         32'(full),         32'(m_count == 8));
    check({tag, ".empty"},        32'(empty),        32'(m_count == 0));
    check({tag, ".almost_full"},  32'(almost_full),  32'(m_count >= 6));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(m_count <= 2));
    check({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
    check({tag, ".underflow"},    32'(underflow),    32'(m_unf));
  endtask

  // One clock: drive at negedge, check acceptance and scoreboard before the
  // rising edge, update the model, then check registered state after it.
  task automatic step(input string tag, input logic w, input logic r,
                      input logic c, input logic rs);
    logic       exp_wen;
    logic       exp_ren;
    logic [7:0] got;
    logic [7:0] want;
    @(negedge clk);
    rst = rs; wr = w; rd = r; clr_err = c;
    #1;
    if (rs) begin
      @(posedge clk);
      #1;
      m_count = 0; m_wa = '0; m_ra = '0; m_ovf = 1'b0; m_unf = 1'b0;
      exp_q.delete();
      check_state(tag);
    end else begin
      exp_wen = w && (m_count != 8);
      exp_ren = r && (m_count != 0);
      check({tag, ".wr_en"}, 32'(wr_en), 32'(exp_wen));
      check({tag, ".rd_en"}, 32'(rd_en), 32'(exp_ren));
      if (rd_en) begin
        check({tag, ".sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          want = exp_q.pop_front();
          got  = ram[rd_addr];
          check({tag, ".rdata"}, 32'(got), 32'(want));
        end
      end
      if (wr_en) begin
        ram[wr_addr] = data_ctr;
        exp_q.push_back(data_ctr);
        data_ctr = data_ctr + 8'd1;
      end
      m_ovf = (w && m_count == 8) ? 1'b1 : (c ? 1'b0 : m_ovf);
      m_unf = (r && m_count == 0) ? 1'b1 : (c ? 1'b0 : m_unf);
      if (exp_wen) m_wa = m_wa + 3'd1;
      if (exp_ren) m_ra = m_ra + 3'd1;
      m_count = m_count + int'(exp_wen) - int'(exp_ren);
      @(posedge clk);
      #1;
      check_state(tag);
    end
  endtask

  initial begin
    logic [2:0] wa0;
    logic [2:0] ra0;
    checks = 0; failures = 0;
    m_count = 0; m_wa = '0; m_ra = '0; m_ovf = 1'b0; m_unf = 1'b0;
    data_ctr = 8'h10;
    for (int i = 0; i < 8; i++) ram[i] = 8'h00;
    rst = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0;

    // 1: reset held two cycles with both requests active
    step("rst_a", 1'b1, 1'b1, 1'b0, 1'b1);
    step("rst_b", 1'b1, 1'b1, 1'b0, 1'b1);
    check("rst.count", 32'(count), 32'd0);
    check("rst.empty", 32'(empty), 32'd1);
    check("rst.almost_empty", 32'(almost_empty), 32'd1);

    // 2: fill, then overflow
    for (int i = 0; i < 8; i++) begin
      step("fill", 1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 4) check("fill5.almost_full", 32'(almost_full), 32'd0);
      if (i == 5) check("fill6.almost_full", 32'(almost_full), 32'd1);
    end
    check("full.wr_addr", 32'(wr_addr), 32'd0);
    check("full.count", 32'(count), 32'd8);
    check("full.full", 32'(full), 32'd1);
    step("ovf", 1'b1, 1'b0, 1'b0, 1'b0);
    check("ovf.overflow", 32'(overflow), 32'd1);
    check("ovf.count", 32'(count), 32'd8);

    // 3: read+write while full, then balanced traffic at count 4
    step("full_rw", 1'b1, 1'b1, 1'b0, 1'b0);
    check("full_rw.count", 32'(count), 32'd7);
    for (int i = 0; i < 3; i++) step("drain", 1'b0, 1'b1, 1'b0, 1'b0);
    step("clr_ovf", 1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_ovf.overflow", 32'(overflow), 32'd0);
    wa0 = wr_addr; ra0 = rd_addr;
    for (int i = 0; i < 3; i++) step("bal", 1'b1, 1'b1, 1'b0, 1'b0);
    check("bal.count", 32'(count), 32'd4);
    check("bal.wr_adv", 32'(wr_addr), 32'(3'(wa0 + 3'd3)));
    check("bal.rd_adv", 32'(rd_addr), 32'(3'(ra0 + 3'd3)));

    // 4: underflow, clear racing a fresh error, then clean clear
    for (int i = 0; i < 4; i++) step("empty_out", 1'b0, 1'b1, 1'b0, 1'b0);
    step("unf", 1'b0, 1'b1, 1'b0, 1'b0);
    check("unf.underflow", 32'(underflow), 32'd1);
    step("clr_race", 1'b0, 1'b1, 1'b1, 1'b0);
    check("clr_race.underflow", 32'(underflow), 32'd1);
    step("clr_ok", 1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_ok.underflow", 32'(underflow), 32'd0);

    // 5: bursts of 5 across the pointer wrap
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 5; i++) step("burst_w", 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step("burst_r", 1'b0, 1'b1, 1'b0, 1'b0);
      check("burst.track", 32'(rd_addr), 32'(m_wa));
    end

    // 6: reset mid-burst, then random traffic
    for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    step("mid_rst", 1'b1, 1'b0, 1'b0, 1'b1);
    check("mid_rst.count", 32'(count), 32'd0);
    check("mid_rst.wr_addr", 32'(wr_addr), 32'd0);
    check("mid_rst.rd_addr", 32'(rd_addr), 32'd0);
    for (int i = 0; i < 60; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
